// File: rtl/lane_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lane_renderer_pkg
// Purpose  : Shared constants and types for the lane renderer. Provides the
//            pixel colour codes, the VGA adapter screen geometry and the
//            renderer FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lane_renderer_pkg;

  // Target screen of the VGA adapter
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  // Coordinate width wide enough for either screen axis
  localparam int COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  // Pixel colours, {R,G,B}
  localparam logic [2:0] COL_BG        = 3'b000;
  localparam logic [2:0] COL_NOTE      = 3'b111;
  localparam logic [2:0] COL_HIT_NOTE  = 3'b110;
  localparam logic [2:0] COL_FLASH     = 3'b010;
  localparam logic [2:0] COL_HIT_EMPTY = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Colour of one note slot: the hit-zone slot has its own palette.
  function automatic logic [2:0] slot_colour(input logic hit_slot,
                                             input logic note,
                                             input logic flash);
    if (!hit_slot) return note ? COL_NOTE : COL_BG;
    if (note)      return COL_HIT_NOTE;
    return flash ? COL_FLASH : COL_HIT_EMPTY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_renderer_raster.sv
`default_nettype none
// ============================================================================
// Module   : raster_counter
// Purpose  : Raster-order position counters for one lane rectangle. px runs
//            0..LANE_W-1 innermost, row runs 0..VISIBLE*NOTE_H-1. A sub-row
//            counter tracks the row inside a note slot and decrements the slot
//            index (top slot first) on wrap, so no divider is needed.
// Ports    : clk, resetn  - clock, async active-low reset
//            clear        - restart at pixel 0, slot VISIBLE-1
//            en           - advance one pixel
//            px, row      - current pixel column offset / row
//            slot         - note slot owning the current row
//            last         - current position is the final pixel of the lane
// Revision : 1.0 - initial release
// ============================================================================
module raster_counter
  import lane_renderer_pkg::*;
#(
  parameter int LANE_W  = 16,
  parameter int NOTE_H  = 8,
  parameter int VISIBLE = 15,
  parameter int SLOT_W  = (VISIBLE > 1) ? $clog2(VISIBLE) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               en,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] row,
  output logic [SLOT_W-1:0]  slot,
  output logic               last
);

  localparam logic [COORD_W-1:0] PX_LAST  = COORD_W'(LANE_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(VISIBLE * NOTE_H - 1);
  localparam logic [COORD_W-1:0] SUB_LAST = COORD_W'(NOTE_H - 1);
  localparam logic [SLOT_W-1:0]  SLOT_TOP = SLOT_W'(VISIBLE - 1);

  logic [COORD_W-1:0] sub_row;
  logic               end_of_line;

  assign end_of_line = (px == PX_LAST);
  assign last        = end_of_line && (row == ROW_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px      <= '0;
      row     <= '0;
      sub_row <= '0;
      slot    <= SLOT_TOP;
    end else if (clear) begin
      px      <= '0;
      row     <= '0;
      sub_row <= '0;
      slot    <= SLOT_TOP;
    end else if (en) begin
      if (end_of_line) begin
        px  <= '0;
        row <= row + 1'b1;
        if (sub_row == SUB_LAST) begin
          sub_row <= '0;
          slot    <= slot - 1'b1;  // wraps past 0 only after the last pixel
        end else begin
          sub_row <= sub_row + 1'b1;
        end
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lane_renderer.sv
`default_nettype none
// ============================================================================
// Module   : lane_renderer
// Purpose  : Converts a lane note window into a pixel stream for a 160x120
//            VGA adapter. Each frame request redraws the lane rectangle from a
//            snapshot of the note window and press flag taken at frame start.
// Ports    : clk, resetn  - clock, async active-low reset
//            lane_bits    - note window, bit0 = hit-zone slot
//            hit_flash    - press flag for the hit zone
//            frame_req    - one-cycle redraw request
//            x, y, colour - registered pixel coordinate and colour
//            plot         - pixel valid (adapter write enable)
//            busy         - a frame is being drawn (or is queued back-to-back)
//            done         - one-cycle pulse after the last pixel of a frame
// Revision : 1.0 - initial release
// ============================================================================
module lane_renderer
  import lane_renderer_pkg::*;
#(
  parameter int LANE_X0 = 60,
  parameter int LANE_W  = 16,
  parameter int NOTE_H  = 8,
  parameter int VISIBLE = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [VISIBLE-1:0] lane_bits,
  input  logic               hit_flash,
  input  logic               frame_req,
  output logic [7:0]         x,
  output logic [7:0]         y,
  output logic [2:0]         colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int SLOT_W = (VISIBLE > 1) ? $clog2(VISIBLE) : 1;

  state_t               state, next_state;
  logic                 pending;
  logic [VISIBLE-1:0]   snap;
  logic                 flash_snap;
  logic                 cnt_clear, cnt_en;
  logic                 busy_c, done_c;
  logic [COORD_W-1:0]   px, row;
  logic [SLOT_W-1:0]    slot;
  logic                 last;
  logic [2:0]           pixel_colour;
  logic                 start_frame;

  raster_counter #(
    .LANE_W  (LANE_W),
    .NOTE_H  (NOTE_H),
    .VISIBLE (VISIBLE),
    .SLOT_W  (SLOT_W)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .px     (px),
    .row    (row),
    .slot   (slot),
    .last   (last)
  );

  assign pixel_colour = slot_colour(slot == '0, snap[slot], flash_snap);

  // A new frame is accepted from IDLE, or back-to-back from DONE.
  assign start_frame  = (next_state == ST_LOAD) &&
                        ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_req || pending) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_clear  = 1'b1;
        busy_c     = 1'b1;
        next_state = ST_DRAW;
      end
      ST_DRAW: begin
        cnt_en = 1'b1;
        busy_c = 1'b1;
        if (last) next_state = ST_DONE;
      end
      ST_DONE: begin
        done_c = 1'b1;
        // Keep busy asserted when another frame follows immediately.
        busy_c = pending || frame_req;
        next_state = (pending || frame_req) ? ST_LOAD : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      pending    <= 1'b1;  // draw one frame automatically after reset
      snap       <= '0;
      flash_snap <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= COL_BG;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= next_state;

      if (start_frame)    pending <= 1'b0;
      else if (frame_req) pending <= 1'b1;

      if (state == ST_LOAD) begin
        snap       <= lane_bits;
        flash_snap <= hit_flash;
      end

      plot <= cnt_en;
      busy <= busy_c;
      done <= done_c;
      if (cnt_en) begin
        x      <= 8'(LANE_X0) + px;
        y      <= row;
        colour <= pixel_colour;
      end
    end
  end

endmodule
`default_nettype wire
